// File: rtl/instruction_loader.sv
// instruction_loader
//   Write-side master for instruction_memory. Collects bytes from the debug UART
//   receiver over a valid/ready handshake, packs them MSB-first into instruction
//   words and writes each completed word into the memory. A load starts on
//   i_start. It ends on the HALT word (o_load_done) or when the memory is full
//   (o_load_error).
//
// Ports
//   i_clk, i_reset           clock (rising edge) and asynchronous active-low reset
//   i_start                  single-cycle request to begin a load
//   i_byte, i_byte_valid     incoming byte and its valid flag
//   o_byte_ready             byte accepted on an edge where valid and ready are both 1
//   o_clear_mem              single-cycle clear pulse to instruction_memory
//   o_instruction_write      single-cycle write strobe to instruction_memory
//   o_instruction            assembled word; holds its value between strobes
//   o_word_count             words written in this load, HALT included
//   o_load_done              level: the load ended on the HALT word
//   o_load_error             level: the memory filled up without a HALT word
module instruction_loader #(
    parameter int unsigned WORD_SIZE_IN_BYTES = 4,
    parameter int unsigned MEM_SIZE_IN_WORDS  = 10,
    parameter logic [WORD_SIZE_IN_BYTES*8-1:0] HALT_INSTRUCTION =
        {{(WORD_SIZE_IN_BYTES*8-1){1'b0}}, 1'b1}
) (
    input  logic                                       i_clk,
    input  logic                                       i_reset,
    input  logic                                       i_start,
    input  logic [7:0]                                 i_byte,
    input  logic                                       i_byte_valid,
    output logic                                       o_byte_ready,
    output logic                                       o_clear_mem,
    output logic                                       o_instruction_write,
    output logic [WORD_SIZE_IN_BYTES*8-1:0]            o_instruction,
    output logic [$clog2(MEM_SIZE_IN_WORDS+1)-1:0]     o_word_count,
    output logic                                       o_load_done,
    output logic                                       o_load_error
);

    localparam int unsigned WORD_W = WORD_SIZE_IN_BYTES * 8;
    localparam int unsigned CNT_W  = $clog2(MEM_SIZE_IN_WORDS + 1);
    localparam int unsigned IDX_W  = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StReceive,
        StWrite,
        StDone,
        StError
    } state_e;

    state_e             state;
    logic [IDX_W-1:0]   byte_idx;
    logic [WORD_W-1:0]  word_buf;

    logic [WORD_W-1:0]  word_next;
    logic [CNT_W-1:0]   count_next;
    logic               last_byte;
    logic               accept;

    always_comb begin
        word_next = word_buf;
        // First byte of a word lands in the top byte lane.
        word_next[(WORD_SIZE_IN_BYTES - 1 - int'(byte_idx)) * 8 +: 8] = i_byte;
        count_next = o_word_count + CNT_W'(1);
        last_byte  = (byte_idx == IDX_W'(WORD_SIZE_IN_BYTES - 1));
        accept     = i_byte_valid && o_byte_ready;
    end

    // All outputs are registered: each one is set on the edge that enters the
    // state in which it must be visible.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state               <= StIdle;
            byte_idx            <= '0;
            word_buf            <= '0;
            o_byte_ready        <= 1'b0;
            o_clear_mem         <= 1'b0;
            o_instruction_write <= 1'b0;
            o_instruction       <= '0;
            o_word_count        <= '0;
            o_load_done         <= 1'b0;
            o_load_error        <= 1'b0;
        end else begin
            o_clear_mem         <= 1'b0;
            o_instruction_write <= 1'b0;

            unique case (state)
                StIdle, StDone, StError: begin
                    o_byte_ready <= 1'b0;
                    if (i_start) begin
                        state        <= StClear;
                        o_clear_mem  <= 1'b1;
                        o_word_count <= '0;
                        byte_idx     <= '0;
                        o_load_done  <= 1'b0;
                        o_load_error <= 1'b0;
                    end
                end

                StClear: begin
                    state        <= StReceive;
                    o_byte_ready <= 1'b1;
                end

                StReceive: begin
                    if (accept) begin
                        word_buf <= word_next;
                        if (last_byte) begin
                            byte_idx            <= '0;
                            state               <= StWrite;
                            o_byte_ready        <= 1'b0;
                            o_instruction_write <= 1'b1;
                            o_instruction       <= word_next;
                        end else begin
                            byte_idx <= byte_idx + IDX_W'(1);
                        end
                    end
                end

                StWrite: begin
                    o_word_count <= count_next;
                    // HALT takes priority, so a HALT in the last slot is a clean finish.
                    if (o_instruction == HALT_INSTRUCTION) begin
                        state       <= StDone;
                        o_load_done <= 1'b1;
                    end else if (count_next == CNT_W'(MEM_SIZE_IN_WORDS)) begin
                        state        <= StError;
                        o_load_error <= 1'b1;
                    end else begin
                        state        <= StReceive;
                        o_byte_ready <= 1'b1;
                    end
                end

                default: begin
                    state        <= StIdle;
                    o_byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Write-side master for instruction_memory. Accepts a byte stream (from the debug UART receiver) over a valid/ready handshake and assembles bytes into instruction words. Drives the memory's clear, write-strobe and data inputs, and stops loading on a HALT word or when the memory is full. Sits between the UART RX path and the IF-stage instruction memory, and is controlled by the debug unit through i_start.

Parameters:
WORD_SIZE_IN_BYTES, 4, bytes per instruction word; must match instruction_memory.
MEM_SIZE_IN_WORDS, 10, instruction memory capacity in words.
HALT_INSTRUCTION, 32'h00000001, word value that terminates a load; width WORD_SIZE_IN_BYTES*8.

Ports:
i_clk  in  1  system clock, rising-edge.
i_reset  in  1  asynchronous, active-low reset.
i_start  in  1  single-cycle request to begin a load.
i_byte  in  8  received byte.
i_byte_valid  in  1  i_byte holds a valid byte.
o_byte_ready  out  1  loader accepts a byte this cycle.
o_clear_mem  out  1  single-cycle clear to instruction_memory.
o_instruction_write  out  1  single-cycle write strobe to instruction_memory.
o_instruction  out  WORD_SIZE_IN_BYTES*8  assembled word to instruction_memory.
o_word_count  out  $clog2(MEM_SIZE_IN_WORDS+1)  words written in the current load, HALT included.
o_load_done  out  1  level: load ended on a HALT word.
o_load_error  out  1  level: memory filled without a HALT word.

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE. All outputs 0, including o_instruction and o_word_count. Byte index 0.
- Byte transfer: a byte is accepted only on a rising edge with i_byte_valid=1 and o_byte_ready=1. o_byte_ready is registered and is 1 only in RECEIVE.
- Byte order: MSB first. The first accepted byte goes to bits [W*8-1 : W*8-8], the last to [7:0].
- IDLE: o_byte_ready=0. i_start=1 -> CLEAR.
- CLEAR (1 cycle):
  - o_clear_mem=1.
  - o_word_count, byte index, o_load_done and o_load_error cleared.
  - -> RECEIVE.
- RECEIVE:
  - Each accepted byte is stored at the current byte index, and the index increments.
  - When the byte at index W-1 is accepted, the index wraps to 0 -> WRITE.
  - Bytes offered with valid=1 while ready=0 are not consumed; the source holds them.
- WRITE (1 cycle):
  - o_instruction_write=1, o_instruction = assembled word, o_byte_ready=0.
  - o_word_count increments.
  - Next state, in priority order: word==HALT_INSTRUCTION -> DONE; else new count==MEM_SIZE_IN_WORDS -> ERROR; else -> RECEIVE.
  - A HALT written into the last slot -> DONE, not ERROR.
- Latency: write strobe on the cycle after the edge that accepts the last byte of a word. Back-to-back words therefore need at least W+1 cycles each.
- DONE: o_load_done=1 (held). ERROR: o_load_error=1 (held). In both states o_byte_ready=0, and i_start=1 -> CLEAR.
- i_start is ignored in CLEAR, RECEIVE and WRITE. No partial word is ever written.
- o_instruction holds its last written value between strobes.
- o_instruction_write and o_clear_mem are never high in the same cycle.
- Reset asserted mid-load: immediate return to IDLE, the partial word is discarded, and no strobe is issued.

Test Plan:
- Basic load: reset, then i_start pulse. Expect o_clear_mem high for exactly 1 cycle. Send bytes 20,01,00,05 then 00,00,00,01. Expect strobes with o_instruction=32'h20010005 and then 32'h00000001. Expect o_load_done=1, o_word_count=2, o_load_error=0.
- Backpressure and gaps: send bytes 8C,22,00,04 with 0-20 random idle cycles between them, and hold valid high across the WRITE cycle. Expect a single strobe with 32'h8C220004, no byte lost or duplicated, and ready=0 during WRITE.
- Overflow: MEM_SIZE_IN_WORDS=10, stream 10 non-HALT random words. Expect 10 strobes, o_load_error=1, o_word_count=10, ready=0 afterwards, and extra bytes not consumed.
- HALT in last slot: 9 random words, then 00,00,00,01. Expect o_load_done=1, o_load_error=0, o_word_count=10.
- Restart and ignored start: from DONE, pulse i_start. Expect a clear pulse, and o_word_count/o_load_done to return to 0. Pulse i_start again after 2 bytes have been accepted. Expect no clear pulse and the word completed normally.
- Async reset mid-word: drop i_reset after 3 of 4 bytes. Expect all outputs 0 immediately, with no clock edge needed. After release and a fresh load, the first strobe carries only the new bytes.
